dyt_writeback_stage: RTL and testbench

Final pipeline stage of the CPU. Accepts completed instructions from the memory stage, waits for load data from data memory when needed, and formats and sign-extends sub-word loads. Drives the register file write port (rf_wen, rf_w_data, rf_w_sel of dyt_register_file_if) one entry per cycle, with a single-entry buffer and a valid/ready handshake upstream.

---
 rtl/dyt_writeback_stage.sv | 132 +++++++++++++
 tb/tb_dyt_writeback_stage.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/dyt_writeback_stage.sv
// Writeback stage: holds one completed instruction, waits for load data when
// needed, formats sub-word loads and drives the register file write port.
//
// state  | meaning
// -------+--------------------------------------------------------------
// EMPTY  | no entry held
// WAIT   | load captured, data memory response outstanding
// FULL   | result ready; entry writes back / retires this cycle
module dyt_writeback_stage (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic        mem_reg_write,
    input  logic [4:0]  mem_rd,
    input  logic        mem_is_load,
    input  logic [2:0]  mem_load_fmt,
    input  logic [1:0]  mem_addr_lo,
    input  logic [31:0] mem_result,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        rf_wen,
    output logic [4:0]  rf_w_sel,
    output logic [31:0] rf_w_data,
    output logic        wb_retire,
    output logic        wb_busy
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t      state_q, state_d;

    logic        reg_write_q;
    logic [4:0]  rd_q;
    logic        is_load_q;
    logic [2:0]  load_fmt_q;
    logic [1:0]  addr_lo_q;
    logic [31:0] data_q;

    logic        accept;
    logic        load_done;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;

    assign mem_ready = (state_q != ST_WAIT);
    assign accept    = mem_valid && mem_ready;
    assign load_done = (state_q == ST_WAIT) && is_load_q && dmem_rvalid;

    // Next-state logic; a FULL entry retires while a new one is accepted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY, ST_FULL: begin
                if (accept) begin
                    state_d = mem_is_load ? ST_WAIT : ST_FULL;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_WAIT: begin
                if (load_done) begin
                    state_d = ST_FULL;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Lane selection and sign/zero extension of the raw memory word.
    // Halfword misalignment is trapped upstream, so addr_lo[0] is ignored.
    always_comb begin
        byte_sel  = 8'h00;
        half_sel  = 16'h0000;
        load_data = dmem_rdata;
        case (addr_lo_q)
            2'd0:    byte_sel = dmem_rdata[7:0];
            2'd1:    byte_sel = dmem_rdata[15:8];
            2'd2:    byte_sel = dmem_rdata[23:16];
            default: byte_sel = dmem_rdata[31:24];
        endcase
        half_sel = addr_lo_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (load_fmt_q)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_data = {24'h000000, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_data = {16'h0000, half_sel};
            default: load_data = dmem_rdata;
        endcase
    end

    // Held entry: control fields on accept, data from ALU or formatted load.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            reg_write_q <= 1'b0;
            rd_q        <= 5'd0;
            is_load_q   <= 1'b0;
            load_fmt_q  <= 3'd0;
            addr_lo_q   <= 2'd0;
            data_q      <= 32'd0;
        end else if (accept) begin
            reg_write_q <= mem_reg_write;
            rd_q        <= mem_rd;
            is_load_q   <= mem_is_load;
            load_fmt_q  <= mem_load_fmt;
            addr_lo_q   <= mem_addr_lo;
            data_q      <= mem_is_load ? 32'd0 : mem_result;
        end else if (load_done) begin
            data_q      <= load_data;
        end
    end

    assign rf_wen    = (state_q == ST_FULL) && reg_write_q && (rd_q != 5'd0);
    assign rf_w_sel  = rd_q;
    assign rf_w_data = data_q;
    assign wb_retire = (state_q == ST_FULL);
    assign wb_busy   = (state_q != ST_EMPTY);

endmodule

// File: tb/tb_dyt_writeback_stage.sv
// Directed bench for the writeback stage. The driver pushes the expected
// register-file write for every instruction it issues; a monitor pops and
// compares whenever the stage retires.
module tb_dyt_writeback_stage;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        mem_valid = 1'b0;
    logic        mem_ready;
    logic        mem_reg_write = 1'b0;
    logic [4:0]  mem_rd = 5'd0;
    logic        mem_is_load = 1'b0;
    logic [2:0]  mem_load_fmt = 3'd0;
    logic [1:0]  mem_addr_lo = 2'd0;
    logic [31:0] mem_result = 32'd0;
    logic        dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = 32'd0;
    logic        rf_wen;
    logic [4:0]  rf_w_sel;
    logic [31:0] rf_w_data;
    logic        wb_retire;
    logic        wb_busy;

    typedef struct {
        logic        wen;
        logic [4:0]  sel;
        logic [31:0] data;
    } wb_exp_t;

    wb_exp_t exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    dyt_writeback_stage dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_reg_write(mem_reg_write),
        .mem_rd       (mem_rd),
        .mem_is_load  (mem_is_load),
        .mem_load_fmt (mem_load_fmt),
        .mem_addr_lo  (mem_addr_lo),
        .mem_result   (mem_result),
        .dmem_rvalid  (dmem_rvalid),
        .dmem_rdata   (dmem_rdata),
        .rf_wen       (rf_wen),
        .rf_w_sel     (rf_w_sel),
        .rf_w_data    (rf_w_data),
        .wb_retire    (wb_retire),
        .wb_busy      (wb_busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: every retire must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (nRST && wb_retire) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_retire", 32'd1, 32'd0);
            end else begin
                wb_exp_t e;
                e = exp_q.pop_front();
                chk("rf_wen",    {31'd0, rf_wen}, {31'd0, e.wen});
                chk("rf_w_sel",  {27'd0, rf_w_sel}, {27'd0, e.sel});
                chk("rf_w_data", rf_w_data, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_nl(input logic rw, input logic [4:0] rd, input logic [31:0] res);
        wb_exp_t e;
        chk("ready_before_nonload", {31'd0, mem_ready}, 32'd1);
        mem_valid = 1'b1; mem_reg_write = rw; mem_rd = rd;
        mem_is_load = 1'b0; mem_result = res;
        e.wen = rw && (rd != 5'd0); e.sel = rd; e.data = res;
        exp_q.push_back(e);
        tick();
        mem_valid = 1'b0; mem_result = 32'hDEAD_BEEF;
    endtask

    task automatic send_ld(input logic rw, input logic [4:0] rd, input logic [2:0] fmt,
                           input logic [1:0] alo, input logic [31:0] word,
                           input int delay, input logic [31:0] res);
        wb_exp_t e;
        chk("ready_before_load", {31'd0, mem_ready}, 32'd1);
        mem_valid = 1'b1; mem_reg_write = rw; mem_rd = rd; mem_is_load = 1'b1;
        mem_load_fmt = fmt; mem_addr_lo = alo; mem_result = 32'hCAFE_F00D;
        e.wen = rw && (rd != 5'd0); e.sel = rd; e.data = res;
        exp_q.push_back(e);
        tick();
        mem_valid = 1'b0; mem_is_load = 1'b0;
        for (int i = 0; i < delay; i++) begin
            chk("ready_low_in_wait", {31'd0, mem_ready}, 32'd0);
            if (i == delay - 1) begin
                dmem_rvalid = 1'b1; dmem_rdata = word;
            end else begin
                dmem_rdata = ~word;
            end
            tick();
            dmem_rvalid = 1'b0; dmem_rdata = 32'h5A5A_5A5A;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset asserted from time zero; outputs must be cleared before any edge.
        #3;
        chk("rst_rf_wen",    {31'd0, rf_wen}, 32'd0);
        chk("rst_rf_w_sel",  {27'd0, rf_w_sel}, 32'd0);
        chk("rst_rf_w_data", rf_w_data, 32'd0);
        chk("rst_retire",    {31'd0, wb_retire}, 32'd0);
        chk("rst_busy",      {31'd0, wb_busy}, 32'd0);
        chk("rst_ready",     {31'd0, mem_ready}, 32'd1);
        @(posedge CLK); @(posedge CLK);
        #3 nRST = 1'b1;
        tick(); tick();
        chk("idle_busy",  {31'd0, wb_busy}, 32'd0);
        chk("idle_ready", {31'd0, mem_ready}, 32'd1);
        chk("idle_wen",   {31'd0, rf_wen}, 32'd0);

        // Back-to-back non-loads, including a suppressed write to x0.
        send_nl(1'b1, 5'd5, 32'h11);
        send_nl(1'b1, 5'd6, 32'h22);
        send_nl(1'b1, 5'd0, 32'h33);
        tick();

        // LB with three-cycle memory latency.
        send_ld(1'b1, 5'd7, 3'b000, 2'd2, 32'h12F4_5678, 3, 32'hFFFF_FFF4);

        // Format sweep, with data returned on the first WAIT cycle.
        send_ld(1'b1, 5'd8,  3'b100, 2'd1, 32'h80FF_7F01, 1, 32'h0000_007F);
        send_ld(1'b1, 5'd9,  3'b001, 2'd2, 32'h80FF_7F01, 1, 32'hFFFF_80FF);
        send_ld(1'b1, 5'd10, 3'b101, 2'd0, 32'h80FF_7F01, 1, 32'h0000_7F01);
        send_ld(1'b1, 5'd11, 3'b010, 2'd0, 32'h80FF_7F01, 1, 32'h80FF_7F01);
        send_ld(1'b1, 5'd12, 3'b111, 2'd3, 32'h80FF_7F01, 1, 32'h80FF_7F01);
        send_ld(1'b1, 5'd13, 3'b000, 2'd3, 32'h80FF_7F01, 2, 32'hFFFF_FF80);
        send_ld(1'b1, 5'd14, 3'b001, 2'd3, 32'h80FF_7F01, 1, 32'hFFFF_80FF);
        send_ld(1'b1, 5'd15, 3'b100, 2'd2, 32'h80FF_7F01, 1, 32'h0000_00FF);
        // Load without reg_write still waits and retires, but writes nothing.
        send_ld(1'b0, 5'd16, 3'b010, 2'd0, 32'h0BAD_F00D, 2, 32'h0BAD_F00D);
        send_nl(1'b1, 5'd17, 32'h1234_5678);
        tick(); tick();

        // Stray rvalid while EMPTY changes nothing.
        chk("pre_stray_busy", {31'd0, wb_busy}, 32'd0);
        dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        tick();
        dmem_rvalid = 1'b0;
        chk("stray_busy",  {31'd0, wb_busy}, 32'd0);
        chk("stray_ready", {31'd0, mem_ready}, 32'd1);
        chk("stray_data",  rf_w_data, 32'h1234_5678);
        tick();

        // Reset while a load is outstanding drops it; later rvalid is ignored.
        mem_valid = 1'b1; mem_reg_write = 1'b1; mem_rd = 5'd20; mem_is_load = 1'b1;
        mem_load_fmt = 3'b010; mem_addr_lo = 2'd0;
        tick();
        mem_valid = 1'b0; mem_is_load = 1'b0;
        chk("wait_busy",  {31'd0, wb_busy}, 32'd1);
        chk("wait_ready", {31'd0, mem_ready}, 32'd0);
        #2 nRST = 1'b0;
        #1;
        chk("midrst_busy",  {31'd0, wb_busy}, 32'd0);
        chk("midrst_ready", {31'd0, mem_ready}, 32'd1);
        #1 nRST = 1'b1;
        tick();
        dmem_rvalid = 1'b1; dmem_rdata = 32'h7777_7777;
        tick();
        dmem_rvalid = 1'b0;
        chk("postrst_busy",   {31'd0, wb_busy}, 32'd0);
        chk("postrst_wen",    {31'd0, rf_wen}, 32'd0);
        chk("postrst_retire", {31'd0, wb_retire}, 32'd0);
        chk("postrst_data",   rf_w_data, 32'd0);
        chk("postrst_sel",    {27'd0, rf_w_sel}, 32'd0);
        tick(); tick();

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
